// File: rtl/hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_stall_ctrl
//
// Stall/flush controller for the 5-stage pipeline. It handles the hazards the
// forwarding unit cannot bypass:
//   - load-use hazards: the front end is frozen and bubbles are inserted into ID/EX
//   - data-memory wait states: the whole pipeline is frozen
//   - taken branches: IF/ID and ID/EX are flushed
// The priority within a cycle is memory wait > taken branch > load-use.
//
// Parameters
//   LOAD_LAT     bubbles inserted per load-use hazard (1..7)
//   MEM_TIMEOUT  wait cycles after which mem_timeout asserts (1..65535)
//
// Ports
//   clk              in   pipeline clock, rising edge
//   rst_n            in   asynchronous active-low reset
//   rs1_ID, rs2_ID   in   source registers of the instruction in ID
//   uses_rs2_ID      in   instruction in ID reads rs2
//   rd_EX            in   destination register of the instruction in EX
//   MemRead_EX       in   instruction in EX is a load
//   branch_taken_EX  in   branch/jump resolved taken in EX
//   mem_req_MEM      in   instruction in MEM accesses data memory
//   mem_ready_MEM    in   data memory completes the access this cycle
//   pc_write         out  PC update enable
//   ifid_write       out  IF/ID register enable
//   ifid_flush       out  clear IF/ID to NOP
//   idex_bubble      out  load NOP into ID/EX
//   idex_flush       out  clear ID/EX to NOP
//   back_hold        out  hold EX/MEM and MEM/WB; no register-file write
//   mem_timeout      out  sticky error: memory wait reached MEM_TIMEOUT cycles
//
// Optional feature (macro HAZARD_PERF_CNT_EN)
//   perf_clr         in   synchronous clear of both performance counters
//   stall_cycles     out  cycles with pc_write=0, saturating
//   flush_count      out  taken-branch flushes, saturating
// -----------------------------------------------------------------------------
module hazard_stall_ctrl #(
  parameter int LOAD_LAT    = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  rs1_ID,
  input  logic [4:0]  rs2_ID,
  input  logic        uses_rs2_ID,
  input  logic [4:0]  rd_EX,
  input  logic        MemRead_EX,
  input  logic        branch_taken_EX,
  input  logic        mem_req_MEM,
  input  logic        mem_ready_MEM,
  output logic        pc_write,
  output logic        ifid_write,
  output logic        ifid_flush,
  output logic        idex_bubble,
  output logic        idex_flush,
  output logic        back_hold,
  output logic        mem_timeout
`ifdef HAZARD_PERF_CNT_EN
  ,
  input  logic        perf_clr,
  output logic [31:0] stall_cycles,
  output logic [15:0] flush_count
`endif
);

  localparam int BW = $clog2(LOAD_LAT + 1);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(LOAD_LAT - 1);
  localparam logic [WW-1:0] W_ONE  = WW'(1);
  localparam logic [WW-1:0] W_MAX  = WW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } state_t;

  // State registers
  state_t          r_state;
  state_t          r_ret_state;   // where MEM_WAIT goes back to
  logic [BW-1:0]   r_bcnt;        // bubbles already inserted for the current load
  logic [WW-1:0]   r_wcnt;        // wait cycles already spent in the current access
  logic            r_timeout;

  // Combinational decode
  logic            w_lu;
  logic            w_mw;
  state_t          w_eff_state;
  state_t          w_state_next;
  state_t          w_ret_next;
  logic [BW-1:0]   w_bcnt_next;
  logic [WW-1:0]   w_wcnt_next;
  logic            w_freeze;
  logic            w_stall;
  logic            w_flush;
  logic            w_to_hit;

  assign w_lu = MemRead_EX && (rd_EX != 5'd0) &&
                ((rd_EX == rs1_ID) || (uses_rs2_ID && (rd_EX == rs2_ID)));

  assign w_mw = mem_req_MEM && !mem_ready_MEM;

  // The cycle the memory completes, the freeze is released immediately: that
  // cycle is evaluated as if we were already back in the saved return state,
  // so a pending branch flush or a remaining load-use bubble applies at once.
  assign w_eff_state = ((r_state == ST_MEM_WAIT) && !w_mw) ? r_ret_state : r_state;

  always_comb begin
    w_state_next = r_state;
    w_ret_next   = r_ret_state;
    w_bcnt_next  = r_bcnt;
    w_wcnt_next  = r_wcnt;
    w_freeze     = 1'b0;
    w_stall      = 1'b0;
    w_flush      = 1'b0;

    case (w_eff_state)
      ST_RUN: begin
        w_state_next = ST_RUN;
        if (w_mw) begin
          w_freeze     = 1'b1;
          w_state_next = ST_MEM_WAIT;
          w_ret_next   = ST_RUN;
          w_wcnt_next  = W_ONE;
        end else if (branch_taken_EX) begin
          // The ID instruction is squashed, so a coincident load-use is moot.
          w_flush = 1'b1;
        end else if (w_lu) begin
          w_stall = 1'b1;
          if (LOAD_LAT > 1) begin
            w_state_next = ST_LU_STALL;
            w_bcnt_next  = B_ONE;
          end
        end
      end

      ST_LU_STALL: begin
        w_state_next = ST_LU_STALL;
        if (w_mw) begin
          // Bubble count is kept so the remaining bubbles follow the wait.
          w_freeze     = 1'b1;
          w_state_next = ST_MEM_WAIT;
          w_ret_next   = ST_LU_STALL;
          w_wcnt_next  = W_ONE;
        end else begin
          w_stall = 1'b1;
          if (r_bcnt >= B_LAST) begin
            w_state_next = ST_RUN;
            w_bcnt_next  = '0;
          end else begin
            w_bcnt_next  = r_bcnt + B_ONE;
          end
        end
      end

      ST_MEM_WAIT: begin
        // Only reached while the access is still pending (see w_eff_state);
        // branch and load-use requests are masked here.
        w_freeze     = 1'b1;
        w_state_next = ST_MEM_WAIT;
        w_wcnt_next  = (r_wcnt == W_MAX) ? W_MAX : (r_wcnt + W_ONE);
      end

      default: begin
        w_state_next = ST_RUN;
        w_ret_next   = ST_RUN;
      end
    endcase
  end

  // w_wcnt_next is the ordinal of the current wait cycle, so the flag rises in
  // the MEM_TIMEOUT-th frozen cycle rather than one cycle later.
  assign w_to_hit = w_freeze && (w_wcnt_next == W_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_ret_state <= ST_RUN;
      r_bcnt      <= '0;
      r_wcnt      <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ret_state <= w_ret_next;
      r_bcnt      <= w_bcnt_next;
      r_wcnt      <= w_wcnt_next;
      r_timeout   <= r_timeout | w_to_hit;
    end
  end

  // Outputs are combinational from state and inputs. They are also forced to
  // their idle values while rst_n is low, so a hazard present on the inputs
  // during reset cannot stall or flush the pipeline.
  logic w_pc_write;
  assign w_pc_write = !(w_freeze || w_stall);

  assign pc_write    = w_pc_write            || !rst_n;
  assign ifid_write  = !(w_freeze || w_stall) || !rst_n;
  assign ifid_flush  = w_flush               && rst_n;
  assign idex_flush  = w_flush               && rst_n;
  assign idex_bubble = w_stall               && rst_n;
  assign back_hold   = w_freeze              && rst_n;
  assign mem_timeout = (r_timeout || w_to_hit) && rst_n;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [15:0] r_flush_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else if (perf_clr) begin
      r_stall_cycles <= '0;
      r_flush_count  <= '0;
    end else begin
      if (!w_pc_write && (r_stall_cycles != 32'hFFFF_FFFF)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_flush && (r_flush_count != 16'hFFFF)) begin
        r_flush_count <= r_flush_count + 16'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_count  = r_flush_count;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_stall_ctrl
//
// Two controllers share one set of inputs: one with LOAD_LAT=1/MEM_TIMEOUT=255
// and one with LOAD_LAT=3/MEM_TIMEOUT=3. Each directed cycle pushes the
// hand-computed expected output vectors of both into a queue; a monitor on the
// falling edge pops and compares them against the live outputs.
// Output vector bit order: {pc_write, ifid_write, ifid_flush, idex_bubble,
//                           idex_flush, back_hold, mem_timeout}
// -----------------------------------------------------------------------------
module tb_hazard_stall_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic [4:0] rs1_ID = '0;
  logic [4:0] rs2_ID = '0;
  logic       uses_rs2_ID = 1'b0;
  logic [4:0] rd_EX = '0;
  logic       MemRead_EX = 1'b0;
  logic       branch_taken_EX = 1'b0;
  logic       mem_req_MEM = 1'b0;
  logic       mem_ready_MEM = 1'b0;

  logic a_pc, a_iw, a_if, a_ib, a_xf, a_bh, a_to;
  logic b_pc, b_iw, b_if, b_ib, b_xf, b_bh, b_to;
  logic [6:0] o1_vec, o3_vec;
  assign o1_vec = {a_pc, a_iw, a_if, a_ib, a_xf, a_bh, a_to};
  assign o3_vec = {b_pc, b_iw, b_if, b_ib, b_xf, b_bh, b_to};

`ifdef HAZARD_PERF_CNT_EN
  logic        perf_clr = 1'b0;
  logic [31:0] a_stall, b_stall;
  logic [15:0] a_flush, b_flush;
  int          exp_stall1, exp_stall3, exp_flush1, exp_flush3;
`endif

  hazard_stall_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(255)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs2_ID(uses_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
    .pc_write(a_pc), .ifid_write(a_iw), .ifid_flush(a_if), .idex_bubble(a_ib),
    .idex_flush(a_xf), .back_hold(a_bh), .mem_timeout(a_to)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_clr(perf_clr), .stall_cycles(a_stall), .flush_count(a_flush)
`endif
  );

  hazard_stall_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .uses_rs2_ID(uses_rs2_ID),
    .rd_EX(rd_EX), .MemRead_EX(MemRead_EX), .branch_taken_EX(branch_taken_EX),
    .mem_req_MEM(mem_req_MEM), .mem_ready_MEM(mem_ready_MEM),
    .pc_write(b_pc), .ifid_write(b_iw), .ifid_flush(b_if), .idex_bubble(b_ib),
    .idex_flush(b_xf), .back_hold(b_bh), .mem_timeout(b_to)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_clr(perf_clr), .stall_cycles(b_stall), .flush_count(b_flush)
`endif
  );

  localparam logic [6:0] IDLE  = 7'b1100000;
  localparam logic [6:0] IDLET = 7'b1100001;
  localparam logic [6:0] LU    = 7'b0001000;
  localparam logic [6:0] BR    = 7'b1110100;
  localparam logic [6:0] FRZ   = 7'b0000010;
  localparam logic [6:0] FRZT  = 7'b0000011;

  typedef struct {
    string      name;
    logic       rstn;
    logic [6:0] e1;
    logic [6:0] e3;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;

  // One directed cycle: drive inputs just after the rising edge and record
  // what both controllers must present during this cycle.
  task automatic cyc(input string nm, input logic rn,
                     input logic [4:0] rs1, input logic [4:0] rs2, input logic u2,
                     input logic [4:0] rd, input logic mr, input logic br,
                     input logic req, input logic rdy,
                     input logic [6:0] e1, input logic [6:0] e3);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n           = rn;
    rs1_ID          = rs1;
    rs2_ID          = rs2;
    uses_rs2_ID     = u2;
    rd_EX           = rd;
    MemRead_EX      = mr;
    branch_taken_EX = br;
    mem_req_MEM     = req;
    mem_ready_MEM   = rdy;
    e.name = nm;
    e.rstn = rn;
    e.e1   = e1;
    e.e3   = e3;
    sb_q.push_back(e);
  endtask

  task automatic idle(input logic [6:0] e1, input logic [6:0] e3);
    cyc("idle", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, e1, e3);
  endtask

  // Monitor: outputs are combinational, so they are stable by the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_txn++;
      $display("txn %0d %s dut1=%b dut3=%b", n_txn, mon_e.name, o1_vec, o3_vec);
      n_checks++;
      if (o1_vec !== mon_e.e1) begin
        n_fail++;
        $display("FAIL %s dut1 got=%b exp=%b", mon_e.name, o1_vec, mon_e.e1);
      end
      n_checks++;
      if (o3_vec !== mon_e.e3) begin
        n_fail++;
        $display("FAIL %s dut3 got=%b exp=%b", mon_e.name, o3_vec, mon_e.e3);
      end
`ifdef HAZARD_PERF_CNT_EN
      if (!mon_e.rstn) begin
        exp_stall1 = 0; exp_stall3 = 0; exp_flush1 = 0; exp_flush3 = 0;
      end else begin
        if (!mon_e.e1[6]) exp_stall1++;
        if (!mon_e.e3[6]) exp_stall3++;
        if (mon_e.e1[4])  exp_flush1++;
        if (mon_e.e3[4])  exp_flush3++;
      end
`endif
    end
  end

  initial begin
    // Reset with idle inputs
    cyc("reset0", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE);
    cyc("reset1", 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE);
    idle(IDLE, IDLE);

    // Load-use on rs1: one bubble for LOAD_LAT=1, three for LOAD_LAT=3
    cyc("lu_rs1", 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    idle(IDLE, LU);
    idle(IDLE, LU);
    idle(IDLE, IDLE);

    // x0 destination and rs2 qualification
    cyc("x0_dest",    1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, IDLE);
    cyc("rs2_unused", 1'b1, 5'd3, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, IDLE, IDLE);
    cyc("rs2_used",   1'b1, 5'd3, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    idle(IDLE, LU);
    idle(IDLE, LU);
    cyc("no_load",    1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE);

    // Branch with coincident load-use: flush only
    cyc("br_lu", 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, BR, BR);
    idle(IDLE, IDLE);

    // Memory wait with a taken branch: freeze, then flush on ready
    cyc("mw_br",    1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, FRZ);
    cyc("mw_br",    1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, FRZ, FRZ);
    cyc("ready_br", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, BR, BR);
    idle(IDLE, IDLE);

    // Memory wait interrupting a multi-cycle load-use stall
    cyc("lu_rs1",       1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    cyc("mw_in_lu",     1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    cyc("mw_lu_masked", 1'b1, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    cyc("ready_resume", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, LU);
    idle(IDLE, LU);
    idle(IDLE, IDLE);

    // Four wait cycles; MEM_TIMEOUT=3 raises the flag on the third
    cyc("mw1",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    cyc("mw2",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZ);
    cyc("mw3",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZT);
    cyc("mw4",   1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZT);
    cyc("ready", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b1, IDLE, IDLET);
    cyc("sticky", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLET);

    // Asynchronous reset in the middle of a frozen cycle with hazards present
    cyc("mw_pre_rst", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, FRZ, FRZT);
    cyc("async_rst",  1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, IDLE, IDLE);
    cyc("in_reset",   1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, IDLE, IDLE);
    idle(IDLE, IDLE);

    // Normal function after reset release
    cyc("lu_post", 1'b1, 5'd9, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, LU, LU);
    idle(IDLE, LU);
    idle(IDLE, LU);
    cyc("br_post", 1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, BR, BR);
    idle(IDLE, IDLE);

    // Bounded drain of the scoreboard
    for (int i = 0; i < 10 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    @(posedge clk);
    #1;

`ifdef HAZARD_PERF_CNT_EN
    n_checks++;
    if (a_stall !== 32'(exp_stall1)) begin
      n_fail++;
      $display("FAIL stall_cycles dut1 got=%0d exp=%0d", a_stall, exp_stall1);
    end
    n_checks++;
    if (b_stall !== 32'(exp_stall3)) begin
      n_fail++;
      $display("FAIL stall_cycles dut3 got=%0d exp=%0d", b_stall, exp_stall3);
    end
    n_checks++;
    if (a_flush !== 16'(exp_flush1) || b_flush !== 16'(exp_flush3)) begin
      n_fail++;
      $display("FAIL flush_count got=%0d/%0d exp=%0d/%0d", a_flush, b_flush, exp_flush1, exp_flush3);
    end
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    n_checks++;
    if (a_stall !== 32'd0 || b_stall !== 32'd0 || a_flush !== 16'd0 || b_flush !== 16'd0) begin
      n_fail++;
      $display("FAIL perf_clr got=%0d/%0d/%0d/%0d exp=0", a_stall, b_stall, a_flush, b_flush);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
